// File: rtl/br_dumper_if.sv
// br_dumper_if: register-file read port plus dump output stream
//    a         : read address to the register file
//    rd        : combinational read data for address a
//    out_valid : out_data/out_addr hold a word
//    out_ready : consumer accepts the word at a clock edge when valid is high
//    out_data  : captured register value
//    out_addr  : index of the register in out_data
interface br_dumper_if;
   logic [4:0]  a;
   logic [31:0] rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_addr;
   modport master (output a, out_valid, out_data, out_addr, input rd, out_ready);
   modport slave (input a, out_valid, out_data, out_addr, output rd, out_ready);
endinterface

// File: rtl/br_dumper.sv
// br_dumper: streams register-file entries 0..LAST_REG out over a valid/ready port
//    clk   : clock, rising edge
//    reset : asynchronous active-high reset
//    start : begin a dump, sampled only in IDLE
//    abort : cancel a dump in progress
//    busy  : high in every state except IDLE
//    done  : one-cycle pulse after the last word is accepted
//    bus   : register-file read port and output stream
module br_dumper #(
   parameter int LAST_REG = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   br_dumper_if.master bus
);
   typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
   localparam logic [4:0] LR = 5'(LAST_REG);
   state_t     state, state_n;
   logic [4:0] cnt;
   logic       last;
   assign last = cnt == LR;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   // start beats abort in IDLE; elsewhere abort wins, including over a handshake
   always_comb
      state_n = state == IDLE ? (start ? READ : IDLE) :
                abort         ? IDLE :
                state == READ ? SEND :
                state == SEND ? (bus.out_ready ? (last ? FIN : READ) : SEND) :
                IDLE;
   // valid and done are masked by abort so an aborted word is never seen as delivered
   always_comb begin
      bus.a = state == READ ? cnt : 5'd0;
      bus.out_valid = state == SEND && !abort;
      busy = state != IDLE;
      done = state == FIN && !abort;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= 5'd0;
         bus.out_data <= 32'd0;
         bus.out_addr <= 5'd0;
      end else begin
         if (state == IDLE) cnt <= 5'd0;
         else if (state == SEND && bus.out_ready && !abort && !last) cnt <= cnt + 5'd1;
         if (state == READ) begin
            bus.out_data <= bus.rd;
            bus.out_addr <= cnt;
         end
      end
endmodule
